l1_dcache_nway: RTL and testbench
=================================

# l1_dcache_nway

Parametrised, set-associative, write-back L1 data cache. It is the next generation of the fixed-geometry L1 data cache, with configurable data width, set count and associativity, per-set round-robin replacement, dirty-line writeback and an explicit response strobe. It sits between the core load/store port and the L2 request/ready interface.

## Interface
- `ADDR_WIDTH`, 32: request/L2 address width.
- `DATA_WIDTH`, 32: word and block width in bits (one word per block); must be 8·2^k.
- `NUM_SETS`, 64: set count; power of two, ≥2.
- `ASSOCIATIVITY`, 2: ways per set; power of two, 1..8.
- Derived: OFFSET_W = clog2(DATA_WIDTH/8); INDEX_W = clog2(NUM_SETS); TAG_W = ADDR_WIDTH−INDEX_W−OFFSET_W.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `read_enable` in 1: load request.
- `write_enable` in 1: store request; wins if both high.
- `request_address` in ADDR_WIDTH: byte address; offset bits ignored.
- `write_data` in DATA_WIDTH: store data.
- `response_data` out DATA_WIDTH: load data, or stored data on writes.
- `resp_valid` out 1: one-cycle completion strobe.
- `c_state` out 3: FSM state code.
- `l2_request` out 1: L2 transaction pending.
- `l2_write_enable` out 1: 1 = L2 write, 0 = L2 read.
- `l2_address` out ADDR_WIDTH: word-aligned L2 address (offset bits 0).
- `l2_write_data` out DATA_WIDTH: writeback or write-through data.
- `l2_response_data` in DATA_WIDTH: L2 read data, valid with `l2_ready`.
- `l2_ready` in 1: L2 completion, sampled only while `l2_request`=1.

## Operation
- Per way/set: tag, data, valid, dirty. Per set: victim pointer (clog2(ASSOCIATIVITY) bits). Reset clears valid, dirty and pointers. Data and tag arrays are not reset.
- States and codes: IDLE=0, WRITEBACK=1, FILL=2, WTHRU=3, DONE=4.
- IDLE: each rising edge with an enable high is one new access.
  - Read hit: `response_data`←way data; `resp_valid`=1 next cycle; stay IDLE.
  - Write hit: data←`write_data`, dirty=1; `response_data`←`write_data`; `resp_valid` next cycle.
  - Miss: victim is the lowest-index invalid way. If all ways are valid, the victim is the way at the pointer, and the pointer increments mod ASSOCIATIVITY. Hits never move the pointer.
  - Read miss → WRITEBACK if victim valid and dirty, else FILL.
  - Write miss: behaviour per Configuration.
- WRITEBACK: `l2_request`=1, `l2_write_enable`=1, `l2_address`={victim tag, index, 0}, `l2_write_data`=victim data. On `l2_ready`: clear victim dirty → FILL (read) or install (write, macro on).
- FILL: `l2_request`=1, `l2_write_enable`=0, `l2_address`=request word address. On `l2_ready`: install `l2_response_data`, tag, valid=1, dirty=0; `response_data`←fill data → DONE.
- WTHRU: `l2_request`=1, `l2_write_enable`=1, `l2_address`=request word address, `l2_write_data`=`write_data`; on `l2_ready` → DONE. Cache contents unchanged.
- DONE: `resp_valid`=1 for one cycle → IDLE. Inputs are ignored outside IDLE.
- The miss request (address, data, type) is latched at acceptance. A requester dropping its enable mid-miss does not abort; the access completes and strobes.

## Timing
- Reset values: `response_data`=0, `resp_valid`=0, `c_state`=IDLE, `l2_request`=0, `l2_write_enable`=0, `l2_address`=0, `l2_write_data`=0.
- Hit latency: 1 cycle from sampling edge to `resp_valid`.
- Clean read miss: 1 + L + 1 cycles, where L is cycles until `l2_ready`. A dirty victim adds L+1.
- L2 handshake:
  - `l2_request` and its address/data/type are held stable until the edge sampling `l2_ready`=1.
  - `l2_request` is low for at least one cycle between transactions.
  - `l2_ready` while `l2_request`=0 is ignored.
- Requester must deassert its enable on the `resp_valid` cycle. An enable still high on the next IDLE edge is a new access.
- Reset mid-operation: next cycle is IDLE with all lines invalid and `l2_request`=0. The in-flight L2 transaction is abandoned; L2 tolerates this.

## Configuration
- `L1_DCACHE_WRITE_ALLOCATE_EN` defined: a write miss allocates without a fill. A dirty victim is first written back (WRITEBACK). The line is then installed with `write_data`, valid=1 and dirty=1. Then DONE.
- Undefined: a write miss goes to WTHRU (no-write-allocate, write-through to L2). Tags, victim pointer and dirty bits are unchanged.

## Test plan
Defaults throughout (index = addr[7:2]; 0x830, 0x1830 and 0x2830 share index 0x0C). L2 model asserts `l2_ready` 2 cycles after `l2_request`.
- Read 0x830, L2 returns 0xEEEEEEEE → `l2_request` with `l2_address`=0x830 and `l2_write_enable`=0. Then `resp_valid` with 0xEEEEEEEE. Re-read 0x830 → `resp_valid` 1 cycle later with 0xEEEEEEEE and no `l2_request`.
- After filling 0x830 (way0) and 0x1830 (way1), read 0x2830 → way0 evicted, no L2 write. A subsequent read of 0x830 misses.
- Continue: write 0x1830=0x12345678 (hit), then read 0x830 → L2 write of 0x12345678 to 0x1830 precedes the L2 read of 0x830.
- Write miss to 0x4000=0xCAFEF00D:
  - Macro off → one L2 write to 0x4000, cache unchanged; a following read of 0x4000 misses.
  - Macro on → no L2 traffic; a read of 0x4000 hits with 0xCAFEF00D.
- `reset` pulsed while FILL has `l2_request`=1 → next cycle `c_state`=0 and `l2_request`=0. A later read of any previously cached address issues an L2 read.
- `read_enable` and `write_enable` both high on a hit → treated as write; dirty set; `response_data`=`write_data`.

Source files
------------

// File: rtl/l1_dcache_nway.sv
// l1_dcache_nway: set-associative write-back L1 data cache, one word per
// block, per-set round-robin victim pointer, L2 request/ready port.
// Ports: clk, reset (sync, active-high); core side read_enable, write_enable,
// request_address, write_data -> response_data, resp_valid, c_state;
// L2 side l2_request, l2_write_enable, l2_address, l2_write_data,
// l2_response_data, l2_ready.
// Option: L1_DCACHE_WRITE_ALLOCATE_EN selects write-allocate on a write miss;
// left undefined, a write miss is written through to L2 without allocation.
module l1_dcache_nway #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_SETS      = 64,
  parameter int ASSOCIATIVITY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read_enable,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] request_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] response_data,
  output logic                  resp_valid,
  output logic [2:0]            c_state,
  output logic                  l2_request,
  output logic                  l2_write_enable,
  output logic [ADDR_WIDTH-1:0] l2_address,
  output logic [DATA_WIDTH-1:0] l2_write_data,
  input  logic [DATA_WIDTH-1:0] l2_response_data,
  input  logic                  l2_ready
);
  localparam int OFFSET_W = $clog2(DATA_WIDTH / 8);
  localparam int INDEX_W  = $clog2(NUM_SETS);
  localparam int TAG_W    = ADDR_WIDTH - INDEX_W - OFFSET_W;
  localparam int WAY_W    = (ASSOCIATIVITY > 1) ? $clog2(ASSOCIATIVITY) : 1;
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(DATA_WIDTH / 8 - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITEBACK = 3'd1,
    FILL      = 3'd2,
    WTHRU     = 3'd3,
    DONE      = 3'd4
  } state_t;

  logic [TAG_W-1:0]         tag_q   [ASSOCIATIVITY][NUM_SETS];
  logic [DATA_WIDTH-1:0]    data_q  [ASSOCIATIVITY][NUM_SETS];
  logic [ASSOCIATIVITY-1:0] valid_q [NUM_SETS];
  logic [ASSOCIATIVITY-1:0] dirty_q [NUM_SETS];
  logic [WAY_W-1:0]         ptr_q   [NUM_SETS];

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0] req_data_q, req_data_d;
`ifdef L1_DCACHE_WRITE_ALLOCATE_EN
  logic                  req_write_q, req_write_d;
`endif
  logic [WAY_W-1:0]      vway_q, vway_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  l2_req_q, l2_req_d;
  logic                  l2_we_q, l2_we_d;
  logic [ADDR_WIDTH-1:0] l2_addr_q, l2_addr_d;
  logic [DATA_WIDTH-1:0] l2_wdata_q, l2_wdata_d;

  logic [INDEX_W-1:0]    in_idx, r_idx;
  logic [TAG_W-1:0]      in_tag, r_tag;
  logic                  hit, has_inv, vict_dirty;
  logic [WAY_W-1:0]      hit_way, inv_way, vict, ptr_inc;
  logic [ADDR_WIDTH-1:0] vict_addr;
  logic [DATA_WIDTH-1:0] vict_data;

  // single write port into the line arrays
  logic                  line_we, tag_we, dirty_we, dirty_val, ptr_we;
  logic [WAY_W-1:0]      arr_way;
  logic [INDEX_W-1:0]    arr_idx;
  logic [DATA_WIDTH-1:0] arr_data;
  logic [TAG_W-1:0]      arr_tag;

  assign in_idx = request_address[OFFSET_W +: INDEX_W];
  assign in_tag = request_address[ADDR_WIDTH-1 -: TAG_W];
  assign r_idx  = req_addr_q[OFFSET_W +: INDEX_W];
  assign r_tag  = req_addr_q[ADDR_WIDTH-1 -: TAG_W];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = 0; w < ASSOCIATIVITY; w++) begin
      if (valid_q[in_idx][WAY_W'(w)] &&
          tag_q[WAY_W'(w)][in_idx] == in_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    // descending scan leaves the lowest invalid way selected
    for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
      if (!valid_q[in_idx][WAY_W'(w)]) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  assign vict       = has_inv ? inv_way : ptr_q[in_idx];
  assign vict_dirty = !has_inv && dirty_q[in_idx][vict];
  assign vict_data  = data_q[vict][in_idx];
  assign vict_addr  = (ADDR_WIDTH'(tag_q[vict][in_idx]) << (INDEX_W + OFFSET_W))
                    | (ADDR_WIDTH'(in_idx) << OFFSET_W);
  assign ptr_inc    = (ASSOCIATIVITY == 1) ? '0 : ptr_q[in_idx] + WAY_W'(1);

  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    req_data_d   = req_data_q;
`ifdef L1_DCACHE_WRITE_ALLOCATE_EN
    req_write_d  = req_write_q;
`endif
    vway_d       = vway_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = 1'b0;
    l2_req_d     = l2_req_q;
    l2_we_d      = l2_we_q;
    l2_addr_d    = l2_addr_q;
    l2_wdata_d   = l2_wdata_q;
    line_we      = 1'b0;
    tag_we       = 1'b0;
    dirty_we     = 1'b0;
    dirty_val    = 1'b0;
    ptr_we       = 1'b0;
    arr_way      = vway_q;
    arr_idx      = r_idx;
    arr_data     = l2_response_data;
    arr_tag      = r_tag;
    unique case (state_q)
      IDLE: begin
        if (read_enable || write_enable) begin
          req_addr_d  = request_address;
          req_data_d  = write_data;
`ifdef L1_DCACHE_WRITE_ALLOCATE_EN
          req_write_d = write_enable;
`endif
          vway_d      = vict;
          if (hit) begin
            resp_valid_d = 1'b1;
            arr_way      = hit_way;
            arr_idx      = in_idx;
            if (write_enable) begin
              line_we     = 1'b1;
              arr_data    = write_data;
              dirty_we    = 1'b1;
              dirty_val   = 1'b1;
              resp_data_d = write_data;
            end else begin
              resp_data_d = data_q[hit_way][in_idx];
            end
          end else if (write_enable) begin
`ifdef L1_DCACHE_WRITE_ALLOCATE_EN
            ptr_we = !has_inv;
            if (vict_dirty) begin
              state_d    = WRITEBACK;
              l2_req_d   = 1'b1;
              l2_we_d    = 1'b1;
              l2_addr_d  = vict_addr;
              l2_wdata_d = vict_data;
            end else begin
              line_we      = 1'b1;
              tag_we       = 1'b1;
              dirty_we     = 1'b1;
              dirty_val    = 1'b1;
              arr_way      = vict;
              arr_idx      = in_idx;
              arr_data     = write_data;
              arr_tag      = in_tag;
              resp_data_d  = write_data;
              resp_valid_d = 1'b1;
              state_d      = DONE;
            end
`else
            state_d    = WTHRU;
            l2_req_d   = 1'b1;
            l2_we_d    = 1'b1;
            l2_addr_d  = request_address & WORD_MASK;
            l2_wdata_d = write_data;
`endif
          end else begin
            ptr_we = !has_inv;
            if (vict_dirty) begin
              state_d    = WRITEBACK;
              l2_req_d   = 1'b1;
              l2_we_d    = 1'b1;
              l2_addr_d  = vict_addr;
              l2_wdata_d = vict_data;
            end else begin
              state_d   = FILL;
              l2_req_d  = 1'b1;
              l2_we_d   = 1'b0;
              l2_addr_d = request_address & WORD_MASK;
            end
          end
        end
      end
      WRITEBACK: begin
        if (l2_ready) begin
          l2_req_d  = 1'b0;
          dirty_we  = 1'b1;
          dirty_val = 1'b0;
          state_d   = FILL;
`ifdef L1_DCACHE_WRITE_ALLOCATE_EN
          if (req_write_q) begin
            line_we      = 1'b1;
            tag_we       = 1'b1;
            dirty_val    = 1'b1;
            arr_data     = req_data_q;
            resp_data_d  = req_data_q;
            resp_valid_d = 1'b1;
            state_d      = DONE;
          end
`endif
        end
      end
      FILL: begin
        // request stays low one cycle after a writeback before the read
        if (!l2_req_q) begin
          l2_req_d  = 1'b1;
          l2_we_d   = 1'b0;
          l2_addr_d = req_addr_q & WORD_MASK;
        end else if (l2_ready) begin
          l2_req_d     = 1'b0;
          line_we      = 1'b1;
          tag_we       = 1'b1;
          dirty_we     = 1'b1;
          dirty_val    = 1'b0;
          resp_data_d  = l2_response_data;
          resp_valid_d = 1'b1;
          state_d      = DONE;
        end
      end
      WTHRU: begin
        if (l2_ready) begin
          l2_req_d     = 1'b0;
          resp_data_d  = req_data_q;
          resp_valid_d = 1'b1;
          state_d      = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (line_we) data_q[arr_way][arr_idx] <= arr_data;
    if (tag_we)  tag_q[arr_way][arr_idx]  <= arr_tag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[INDEX_W'(s)] <= '0;
        dirty_q[INDEX_W'(s)] <= '0;
        ptr_q[INDEX_W'(s)]   <= '0;
      end
    end else begin
      if (tag_we)   valid_q[arr_idx][arr_way] <= 1'b1;
      if (dirty_we) dirty_q[arr_idx][arr_way] <= dirty_val;
      if (ptr_we)   ptr_q[in_idx]             <= ptr_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_addr_q   <= '0;
      req_data_q   <= '0;
`ifdef L1_DCACHE_WRITE_ALLOCATE_EN
      req_write_q  <= 1'b0;
`endif
      vway_q       <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
      l2_req_q     <= 1'b0;
      l2_we_q      <= 1'b0;
      l2_addr_q    <= '0;
      l2_wdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      req_data_q   <= req_data_d;
`ifdef L1_DCACHE_WRITE_ALLOCATE_EN
      req_write_q  <= req_write_d;
`endif
      vway_q       <= vway_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      l2_req_q     <= l2_req_d;
      l2_we_q      <= l2_we_d;
      l2_addr_q    <= l2_addr_d;
      l2_wdata_q   <= l2_wdata_d;
    end
  end

  assign response_data   = resp_data_q;
  assign resp_valid      = resp_valid_q;
  assign c_state         = state_q;
  assign l2_request      = l2_req_q;
  assign l2_write_enable = l2_we_q;
  assign l2_address      = l2_addr_q;
  assign l2_write_data   = l2_wdata_q;
endmodule

// File: tb/tb_l1_dcache_nway.sv
// tb_l1_dcache_nway: directed plus random accesses against a
// golden-memory / set-state model and a 2-cycle L2 responder.
module tb_l1_dcache_nway;
  localparam int NS = 64;
  localparam int NW = 2;
`ifdef L1_DCACHE_WRITE_ALLOCATE_EN
  localparam bit WALLOC = 1'b1;
`else
  localparam bit WALLOC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        read_enable = 1'b0;
  logic        write_enable = 1'b0;
  logic [31:0] request_address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] response_data;
  logic        resp_valid;
  logic [2:0]  c_state;
  logic        l2_request;
  logic        l2_write_enable;
  logic [31:0] l2_address;
  logic [31:0] l2_write_data;
  logic [31:0] l2_response_data = '0;
  logic        l2_ready = 1'b0;

  always #5 clk = ~clk;

  l1_dcache_nway #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SETS(NS), .ASSOCIATIVITY(NW)
  ) dut (
    .clk(clk), .reset(reset),
    .read_enable(read_enable), .write_enable(write_enable),
    .request_address(request_address), .write_data(write_data),
    .response_data(response_data), .resp_valid(resp_valid),
    .c_state(c_state), .l2_request(l2_request),
    .l2_write_enable(l2_write_enable), .l2_address(l2_address),
    .l2_write_data(l2_write_data), .l2_response_data(l2_response_data),
    .l2_ready(l2_ready)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        log_q[$];
  txn_t        exp_q[$];
  logic [31:0] l2mem[logic [31:0]];
  logic [31:0] gold[logic [31:0]];
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  int          l2_cnt = 0;

  bit          m_valid[NS][NW];
  bit          m_dirty[NS][NW];
  logic [23:0] m_tag[NS][NW];
  logic [31:0] m_data[NS][NW];
  int          m_ptr[NS];

  task automatic chk(input string name, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_pat(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : init_pat(a);
  endfunction

  function automatic logic [31:0] l2_rd(input logic [31:0] a);
    return l2mem.exists(a) ? l2mem[a] : init_pat(a);
  endfunction

  // L2: ready two negedges after request is seen, then released.
  always @(negedge clk) begin
    if (l2_ready) begin
      l2_ready = 1'b0;
      chk("l2_req_drop", l2_request, 1'b0);
    end else if (l2_request && !reset) begin
      l2_cnt++;
      if (l2_cnt == 2) begin
        l2_cnt   = 0;
        l2_ready = 1'b1;
        log_q.push_back('{l2_write_enable, l2_address, l2_write_data});
        if (l2_write_enable) l2mem[l2_address] = l2_write_data;
        else l2_response_data = l2_rd(l2_address);
      end
    end else begin
      l2_cnt = 0;
    end
  end

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < NW; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
    // dirty lines are lost on reset; memory is whatever L2 holds
    gold = l2mem;
  endtask

  task automatic model(input bit we, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] er,
                       output bit eh);
    int s, hw, v;
    logic [23:0] t;
    logic [31:0] wa;
    s  = int'(a[7:2]);
    t  = a[31:8];
    wa = {a[31:2], 2'b00};
    hw = -1;
    v  = -1;
    exp_q.delete();
    for (int w = 0; w < NW; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
    eh = (hw >= 0);
    if (eh) begin
      if (we) begin
        m_data[s][hw]  = d;
        m_dirty[s][hw] = 1'b1;
        gold[wa] = d;
        er = d;
      end else begin
        er = gold_rd(wa);
      end
      return;
    end
    if (we && !WALLOC) begin
      exp_q.push_back('{1'b1, wa, d});
      gold[wa] = d;
      er = d;
      return;
    end
    for (int w = NW - 1; w >= 0; w--)
      if (!m_valid[s][w]) v = w;
    if (v < 0) begin
      v = m_ptr[s];
      m_ptr[s] = (m_ptr[s] + 1) % NW;
    end
    if (m_valid[s][v] && m_dirty[s][v])
      exp_q.push_back('{1'b1, {m_tag[s][v], a[7:2], 2'b00}, m_data[s][v]});
    if (!we) begin
      exp_q.push_back('{1'b0, wa, 32'h0});
      er = gold_rd(wa);
    end else begin
      er = d;
      gold[wa] = d;
    end
    m_valid[s][v] = 1'b1;
    m_tag[s][v]   = t;
    m_data[s][v]  = er;
    m_dirty[s][v] = we;
  endtask

  task automatic access(input bit re, input bit we, input logic [31:0] a,
                        input logic [31:0] d, input string nm);
    logic [31:0] er;
    bit eh, got;
    int cyc;
    model(we, a, d, er, eh);
    log_q.delete();
    @(negedge clk);
    read_enable = re;
    write_enable = we;
    request_address = a;
    write_data = d;
    @(posedge clk);
    #1;
    read_enable = 1'b0;
    write_enable = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      got = resp_valid;
    end
    chk({nm, "/resp"}, got, 1'b1);
    chk({nm, "/data"}, response_data, er);
    if (eh) chk({nm, "/hitlat"}, cyc, 1);
    chk({nm, "/ntxn"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk({nm, "/l2we"}, log_q[i].we, exp_q[i].we);
      chk({nm, "/l2addr"}, log_q[i].addr, exp_q[i].addr);
      if (exp_q[i].we) chk({nm, "/l2wdata"}, log_q[i].data, exp_q[i].data);
    end
    @(negedge clk);
    chk({nm, "/strobe1"}, resp_valid, 1'b0);
    chk({nm, "/idle"}, c_state, 3'd0);
  endtask

  initial begin
    int cyc;
    bit seen;
    logic [31:0] a;
    int op;
    l2mem[32'h830] = 32'hEEEEEEEE;
    model_reset();

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst/response_data", response_data, 32'h0);
    chk("rst/resp_valid", resp_valid, 1'b0);
    chk("rst/c_state", c_state, 3'd0);
    chk("rst/l2_request", l2_request, 1'b0);
    chk("rst/l2_write_enable", l2_write_enable, 1'b0);
    chk("rst/l2_address", l2_address, 32'h0);
    chk("rst/l2_write_data", l2_write_data, 32'h0);
    reset = 1'b0;

    access(1, 0, 32'h830, 0, "rd830_miss");
    access(1, 0, 32'h830, 0, "rd830_hit");
    access(1, 0, 32'h1830, 0, "rd1830_miss");
    access(1, 0, 32'h2830, 0, "rd2830_evict");
    access(0, 1, 32'h1830, 32'h12345678, "wr1830_hit");
    access(1, 0, 32'h830, 0, "rd830_wb");
    access(0, 1, 32'h4000, 32'hCAFEF00D, "wr4000_miss");
    access(1, 0, 32'h4000, 0, "rd4000");
    access(1, 1, 32'h830, 32'h0BADBEEF, "both_hit");
    access(1, 0, 32'h830, 0, "rd830_after_both");

    // reset while a fill is outstanding
    @(negedge clk);
    read_enable = 1'b1;
    request_address = 32'h5830;
    @(posedge clk);
    #1;
    read_enable = 1'b0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 10) begin
      @(negedge clk);
      cyc++;
      seen = l2_request;
    end
    chk("rstfill/req_seen", seen, 1'b1);
    chk("rstfill/l2_address", l2_address, 32'h5830);
    chk("rstfill/l2_we", l2_write_enable, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstfill/c_state", c_state, 3'd0);
    chk("rstfill/l2_request", l2_request, 1'b0);
    model_reset();
    log_q.delete();
    access(1, 0, 32'h830, 0, "rd830_after_rst");
    access(1, 0, 32'h2830, 0, "rd2830_after_rst");

    for (int i = 0; i < 150; i++) begin
      a = ($urandom_range(0, 4) << 8) | ((32'h0C + $urandom_range(0, 1)) << 2)
        | $urandom_range(0, 3);
      op = $urandom_range(0, 2);
      access(op != 1, op != 0, a, $urandom, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
